image_frame_store: RTL and testbench

Image frame store on the other side of the image processor's pixel interface. Receives a 64x64 RGB frame over a load stream and answers the processor's row/column reads with `pixel_in`. Captures the processor's writes in place, then streams the finished frame out. It holds the processor idle until a full frame is loaded, and sequences load, run and dump.

---
 rtl/image_pkg.sv | 28 ++
 rtl/image_frame_store_if.sv | 34 +++
 rtl/image_frame_ram.sv | 27 ++
 rtl/image_frame_store.sv | 161 ++++++++++++++++
 tb/tb_image_frame_store.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared frame-store types, sizes and address helper
package image_pkg;

  localparam int IMG_DIM         = 64;
  localparam int PIX_W           = 24;
  localparam int SEL_W           = $clog2(IMG_DIM);
  localparam int ADDR_W          = 2 * SEL_W;
  localparam int FRAME_PIXELS    = IMG_DIM * IMG_DIM;
  localparam int EXPECTED_WRITES = 2 * FRAME_PIXELS;
  localparam int WR_COUNT_W      = 14;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SEL_W-1:0]  sel_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } fs_state_e;

  // Row-major raster address: row in the upper half, column in the lower.
  function automatic addr_t rc_addr(input sel_t row, input sel_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/image_frame_store_if.sv
// rtl/image_frame_store_if.sv - load stream, processor pixel bus and dump stream
interface image_frame_store_if;
  import image_pkg::*;

  pixel_t load_pixel;
  logic   load_valid;
  logic   load_ready;

  sel_t   row_sel;
  sel_t   col_sel;
  pixel_t pixel_in;
  logic   write_enable;
  pixel_t pixel_out;
  logic   mirror_complete;
  logic   grayscale_complete;
  logic   proc_run;

  pixel_t out_pixel;
  logic   out_valid;
  logic   out_ready;

  modport master (
    output load_pixel, load_valid, row_sel, col_sel, write_enable, pixel_out,
           mirror_complete, grayscale_complete, out_ready,
    input  load_ready, pixel_in, proc_run, out_pixel, out_valid
  );

  modport slave (
    input  load_pixel, load_valid, row_sel, col_sel, write_enable, pixel_out,
           mirror_complete, grayscale_complete, out_ready,
    output load_ready, pixel_in, proc_run, out_pixel, out_valid
  );

endinterface

// File: rtl/image_frame_ram.sv
// rtl/image_frame_ram.sv - 4096x24 working buffer, two async read ports, one sync write
module image_frame_ram
  import image_pkg::*;
(
  input  logic   clk,
  input  logic   we_i,
  input  addr_t  waddr_i,
  input  pixel_t wdata_i,
  input  addr_t  raddr_a_i,
  output pixel_t rdata_a_o,
  input  addr_t  raddr_b_i,
  output pixel_t rdata_b_o
);

  // Contents are intentionally not reset.
  pixel_t mem_q [FRAME_PIXELS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/image_frame_store.sv
// rtl/image_frame_store.sv - frame store sequencing LOAD, RUN, DUMP, DONE
// Optional IMG_FRAME_STORE_WRCOUNT_EN adds a processor write counter and wr_count_err.
module image_frame_store
  import image_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  image_frame_store_if.slave  bus,
  input  logic                start,
  output logic                frame_done
`ifdef IMG_FRAME_STORE_WRCOUNT_EN
  ,
  output logic                wr_count_err
`endif
);

  localparam addr_t LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  fs_state_e state_q;
  addr_t     cnt_q;
  logic      load_ready_q;
  logic      proc_run_q;
  logic      out_valid_q;
  logic      frame_done_q;

  logic      load_fire;
  logic      wr_fire;
  logic      dump_fire;
  logic      ram_we;
  addr_t     ram_waddr;
  pixel_t    ram_wdata;
  logic      unused_mirror;

  // Strobes only act when their state's registered enable is up.
  assign load_fire = bus.load_valid & load_ready_q;
  assign wr_fire   = bus.write_enable & (state_q == ST_RUN);
  assign dump_fire = out_valid_q & bus.out_ready;

  assign unused_mirror = bus.mirror_complete;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cnt_q;
    ram_wdata = bus.load_pixel;
    if (state_q == ST_LOAD) begin
      ram_we = load_fire;
    end else if (state_q == ST_RUN) begin
      ram_we    = wr_fire;
      ram_waddr = rc_addr(bus.row_sel, bus.col_sel);
      ram_wdata = bus.pixel_out;
    end
  end

  image_frame_ram u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .raddr_a_i (rc_addr(bus.row_sel, bus.col_sel)),
    .rdata_a_o (bus.pixel_in),
    .raddr_b_i (cnt_q),
    .rdata_b_o (bus.out_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      load_ready_q <= 1'b0;
      proc_run_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          load_ready_q <= 1'b1;
          if (load_fire) begin
            // Counter wraps to zero on the last beat, ready for DUMP.
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
              state_q      <= ST_RUN;
              load_ready_q <= 1'b0;
              proc_run_q   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.grayscale_complete) begin
            state_q     <= ST_DUMP;
            proc_run_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (dump_fire) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
              state_q      <= ST_DONE;
              out_valid_q  <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q      <= ST_LOAD;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            load_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_LOAD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.proc_run   = proc_run_q;
  assign bus.out_valid  = out_valid_q;
  assign frame_done     = frame_done_q;

`ifdef IMG_FRAME_STORE_WRCOUNT_EN
  logic [WR_COUNT_W-1:0] wr_count_q;
  logic [WR_COUNT_W-1:0] wr_count_d;
  logic                  wr_count_err_q;
  logic                  run_entry;
  logic                  run_exit;
  logic                  load_entry;

  assign run_entry  = (state_q == ST_LOAD) & load_fire & (cnt_q == LAST_ADDR);
  assign run_exit   = (state_q == ST_RUN) & bus.grayscale_complete;
  assign load_entry = (state_q == ST_DONE) & start;

  // Saturate so a runaway processor cannot wrap back to a passing count.
  assign wr_count_d = (wr_fire && (wr_count_q != '1)) ? wr_count_q + 1'b1 : wr_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q     <= '0;
      wr_count_err_q <= 1'b0;
    end else begin
      if (run_entry) begin
        wr_count_q <= '0;
      end else begin
        wr_count_q <= wr_count_d;
      end
      if (load_entry) begin
        wr_count_err_q <= 1'b0;
      end else if (run_exit) begin
        wr_count_err_q <= (wr_count_d != WR_COUNT_W'(EXPECTED_WRITES));
      end
    end
  end

  assign wr_count_err = wr_count_err_q;
`endif

endmodule

// File: tb/tb_image_frame_store.sv
// tb/tb_image_frame_store.sv - directed self-checking bench for image_frame_store
module tb_image_frame_store;
  import image_pkg::*;

  logic clk;
  logic rst_n;
  logic start;
  logic frame_done;
`ifdef IMG_FRAME_STORE_WRCOUNT_EN
  logic wr_count_err;
`endif

  int checks;
  int failures;

  pixel_t exp_mem [FRAME_PIXELS];

  image_frame_store_if bus ();

  image_frame_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .start        (start),
    .frame_done   (frame_done)
`ifdef IMG_FRAME_STORE_WRCOUNT_EN
    ,
    .wr_count_err (wr_count_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic load_frame(input string tag, input pixel_t xor_v);
    int   k;
    int   guard;
    logic acc;
    k = 0;
    guard = 0;
    while (k < FRAME_PIXELS && guard < FRAME_PIXELS + 100) begin
      bus.load_pixel = pixel_t'(k) ^ xor_v;
      bus.load_valid = 1'b1;
      acc = bus.load_ready;
      step();
      if (acc) begin
        exp_mem[k] = pixel_t'(k) ^ xor_v;
        k++;
      end
      guard++;
    end
    bus.load_valid = 1'b0;
    check(tag, k, FRAME_PIXELS);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    bus.out_ready = 1'b1;
    while (frame_done !== 1'b1 && guard < FRAME_PIXELS + 100) begin
      step();
      guard++;
    end
    check(tag, frame_done, 1);
  endtask

  initial begin
    int  p;
    int  guard;
    int  derr;
    int  stall_n;
    bit  hs;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    bus.load_pixel         = '0;
    bus.load_valid         = 1'b0;
    bus.row_sel            = '0;
    bus.col_sel            = '0;
    bus.write_enable       = 1'b0;
    bus.pixel_out          = '0;
    bus.mirror_complete    = 1'b0;
    bus.grayscale_complete = 1'b0;
    bus.out_ready          = 1'b0;

    // Reset state.
    step();
    step();
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_proc_run", bus.proc_run, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    step();
    check("load_ready_rise", bus.load_ready, 1);

    // Ramp load; transition to RUN on the 4096th beat.
    load_frame("load_beats", 24'h000000);
    check("load_ready_drop", bus.load_ready, 0);
    check("proc_run_high", bus.proc_run, 1);

    bus.row_sel = 6'd1;  bus.col_sel = 6'd2;  #1;
    check("pixel_in_1_2", bus.pixel_in, 66);
    bus.row_sel = 6'd63; bus.col_sel = 6'd63; #1;
    check("pixel_in_63_63", bus.pixel_in, 4095);

    // Read during write: old value before the edge, new after.
    bus.row_sel = 6'd5; bus.col_sel = 6'd7;
    bus.write_enable = 1'b1; bus.pixel_out = 24'h00AB00; #1;
    check("rdw_old", bus.pixel_in, 327);
    step();
    check("rdw_new", bus.pixel_in, 24'h00AB00);
    exp_mem[327] = 24'h00AB00;
    bus.write_enable = 1'b0;

    bus.mirror_complete = 1'b1;
    step();
    bus.mirror_complete = 1'b0;
    check("mirror_no_effect", bus.proc_run, 1);

    // Write on the grayscale_complete edge still lands.
    bus.row_sel = 6'd0; bus.col_sel = 6'd0;
    bus.write_enable = 1'b1; bus.pixel_out = 24'h123456;
    bus.grayscale_complete = 1'b1;
    step();
    exp_mem[0] = 24'h123456;
    bus.grayscale_complete = 1'b0;
    check("run_exit_proc_run", bus.proc_run, 0);
    check("run_exit_out_valid", bus.out_valid, 1);

    // Dump with stray writes/loads targeting [1,2], a stall at 100, stray start at 200.
    bus.row_sel = 6'd1; bus.col_sel = 6'd2;
    bus.write_enable = 1'b1; bus.pixel_out = 24'hFFFFFF;
    bus.load_valid = 1'b1; bus.load_pixel = 24'hEEEEEE;
    p = 0; guard = 0; derr = 0; stall_n = 0;
    while (p < FRAME_PIXELS && guard < FRAME_PIXELS + 100) begin
      if (bus.out_valid !== 1'b1 || bus.out_pixel !== exp_mem[p]) derr++;
      if (p == 0)    check("dump_pos0", bus.out_pixel, 24'h123456);
      if (p == 327)  check("dump_pos327", bus.out_pixel, 24'h00AB00);
      if (p == 4095) check("dump_last_not_done", frame_done, 0);
      start = (p == 200);
      if (p == 100 && stall_n < 10) begin
        bus.out_ready = 1'b0;
        stall_n++;
        if (stall_n == 10) begin
          check("stall_hold_pixel", bus.out_pixel, 100);
          check("stall_hold_valid", bus.out_valid, 1);
        end
        hs = 1'b0;
      end else begin
        bus.out_ready = 1'b1;
        hs = 1'b1;
      end
      step();
      if (hs) p++;
      guard++;
    end
    start = 1'b0;
    check("dump_count", p, FRAME_PIXELS);
    check("dump_data_errs", derr, 0);
    check("done_frame_done", frame_done, 1);
    check("done_out_valid", bus.out_valid, 0);

    // DONE ignores writes and loads.
    step();
    step();
    check("done_load_ready", bus.load_ready, 0);
    bus.write_enable = 1'b0;
    bus.load_valid   = 1'b0;
    #1;
    check("buffer_unchanged", bus.pixel_in, 66);

    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_load_ready", bus.load_ready, 1);
    check("restart_frame_done", frame_done, 0);

    // Second frame, then asynchronous reset mid-RUN.
    load_frame("load2_beats", 24'hA5A5A5);
    check("run2_proc_run", bus.proc_run, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_proc_run", bus.proc_run, 0);
    check("async_rst_load_ready", bus.load_ready, 0);
    check("async_rst_frame_done", frame_done, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_load_ready", bus.load_ready, 1);

    // Exactly 4096 beats from a cleared counter reach RUN again.
    load_frame("load3_beats", 24'h5A5A5A);
    check("run3_proc_run", bus.proc_run, 1);
    bus.row_sel = 6'd0; bus.col_sel = 6'd1; #1;
    check("pixel_in_0_1", bus.pixel_in, 24'h5A5A5B);

`ifdef IMG_FRAME_STORE_WRCOUNT_EN
    check("wrc_reset", wr_count_err, 0);
    for (int i = 0; i < 8191; i++) begin
      bus.write_enable = 1'b1;
      bus.row_sel = sel_t'(i >> 6); bus.col_sel = sel_t'(i);
      bus.pixel_out = pixel_t'(i);
      step();
    end
    bus.write_enable = 1'b0;
    bus.grayscale_complete = 1'b1;
    step();
    bus.grayscale_complete = 1'b0;
    check("wrc_8191_err", wr_count_err, 1);
    drain("wrc_drain1");
    start = 1'b1;
    step();
    start = 1'b0;
    check("wrc_clear_on_load", wr_count_err, 0);
    load_frame("wrc_load", 24'h000000);
    for (int i = 0; i < 8191; i++) begin
      bus.write_enable = 1'b1;
      bus.row_sel = sel_t'(i >> 6); bus.col_sel = sel_t'(i);
      bus.pixel_out = pixel_t'(i);
      step();
    end
    bus.grayscale_complete = 1'b1;
    step();
    bus.grayscale_complete = 1'b0;
    bus.write_enable = 1'b0;
    check("wrc_8192_ok", wr_count_err, 0);
    drain("wrc_drain2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
